life_sequencer: RTL

LIFE_SEQUENCER -- requirements
Module: life_sequencer

---
 rtl/life_pkg.sv | 13 +
 rtl/life_tick_div.sv | 25 ++
 rtl/life_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/life_pkg.sv
// Shared constants and types for the Game of Life sequencer.
package life_pkg;
  localparam int BOARD_W   = 64;
  localparam int BOARD_DIM = 8;

  typedef logic [BOARD_W-1:0] board_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_e;
endpackage

// File: rtl/life_tick_div.sv
// Generation tick divider: counts 0..TICK_DIV-1 while enabled and flags the last count.
module life_tick_div #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt;

  assign wrap = (cnt == LAST);

  // Holds its value while disabled so a paused run resumes mid-tick.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + 16'd1;
    end
  end
endmodule

// File: rtl/life_sequencer.sv
// Game of Life run/pause/step sequencer around an external combinational datapath.
// Optional period-2 oscillator detection is enabled with macro LIFE_OSC_DETECT_EN.
module life_sequencer
  import life_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int GEN_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      seed,
  input  logic             load,
  input  logic             run,
  input  logic             step,
  output logic [63:0]      cur_state,
  input  logic [63:0]      next_state,
  output logic [GEN_W-1:0] gen_count,
  output logic             running,
  output logic             stable,
  output logic             osc,
  output logic [1:0]       dbg_state
);
  seq_state_e state;
  logic       wrap;
  logic       tick_en;
  logic       adv_pt;
  logic       same;
  logic       osc_hit;

  assign tick_en   = (state == RUN) && run && !load;
  assign running   = (state == RUN);
  assign dbg_state = state;

  life_tick_div #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (load),
    .en    (tick_en),
    .wrap  (wrap)
  );

  // An advance point is a completed tick while running or a step while paused.
  assign adv_pt = ((state == RUN) && run && wrap) ||
                  ((state == IDLE) && !run && step);
  assign same   = (next_state == cur_state);

`ifdef LIFE_OSC_DETECT_EN
  board_t     prev_state;
  logic [1:0] adv_n;
  logic       osc_q;

  assign osc_hit = (adv_n == 2'd2) && (next_state == prev_state) && !same;
  assign osc     = osc_q;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      prev_state <= '0;
      adv_n      <= 2'd0;
      osc_q      <= 1'b0;
    end else if (adv_pt && !same) begin
      if (osc_hit) begin
        osc_q <= 1'b1;
      end else begin
        prev_state <= cur_state;
        if (adv_n != 2'd2) adv_n <= adv_n + 2'd1;
      end
    end
  end
`else
  assign osc_hit = 1'b0;
  assign osc     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_state <= '0;
      gen_count <= '0;
      stable    <= 1'b0;
    end else if (load) begin
      state     <= IDLE;
      cur_state <= seed;
      gen_count <= '0;
      stable    <= 1'b0;
    end else if (adv_pt) begin
      if (same) begin
        state  <= HALT;
        stable <= 1'b1;
      end else if (osc_hit) begin
        state <= HALT;
      end else begin
        cur_state <= next_state;
        if (gen_count != '1) gen_count <= gen_count + GEN_W'(1);
      end
    end else begin
      case (state)
        IDLE:    if (run) state <= RUN;
        RUN:     if (!run) state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule
